// File: rtl/sensor_disp_scan.sv
// Multi-channel sensor display scanner: latches NUM_CH readings, rotates one
// channel onto DIGITS 7-segment digits plus a two-glyph unit suffix. Binary to
// BCD runs on a sequential double-dabble engine, one bit per cycle.

// Per-digit 7-segment encoder, active-low, bit6=a .. bit0=g.
module sensor_disp_seg (
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);
  // Dash wins over blank so an overflowed value never shows as empty.
  always_comb begin
    seg = 7'b1111111;
    if (dash) begin
      seg = 7'b1111110;
    end else if (!blank) begin
      unique case (bcd)
        4'd0:    seg = 7'b0000001;
        4'd1:    seg = 7'b1001111;
        4'd2:    seg = 7'b0010010;
        4'd3:    seg = 7'b0000110;
        4'd4:    seg = 7'b1001100;
        4'd5:    seg = 7'b0100100;
        4'd6:    seg = 7'b0100000;
        4'd7:    seg = 7'b0001111;
        4'd8:    seg = 7'b0000000;
        4'd9:    seg = 7'b0000100;
        default: seg = 7'b1111111;
      endcase
    end
  end
endmodule

module sensor_disp_scan #(
  parameter  int NUM_CH    = 2,
  parameter  int DATA_W    = 8,
  parameter  int DIGITS    = 2,
  parameter  int DWELL_CYC = 134217728,
  localparam int SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data_i,
  input  logic [NUM_CH-1:0]          ch_valid_i,
  input  logic [NUM_CH*14-1:0]       ch_suffix_i,
  input  logic                       hold_i,
  input  logic                       next_i,
  output logic [7*(DIGITS+2)-1:0]    disp_o,
  output logic [SEL_W-1:0]           ch_sel_o,
  output logic                       upd_o,
  output logic                       ovf_o
);
  localparam int CNT_W = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam int NIB   = DIGITS + 1;          // one spare nibble exposes overflow
  localparam int BCD_W = 4 * NIB;
  localparam int SH_W  = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t                          state_q, state_d;
  logic [NUM_CH-1:0][DATA_W-1:0]   samples_q;
  logic [CNT_W-1:0]                dwell_q;
  logic [SEL_W-1:0]                ch_sel_q, tag_q;
  logic                            pending_q;
  logic [DATA_W-1:0]               bin_q;
  logic [BCD_W-1:0]                bcd_q, bcd_adj;
  logic                            ovf_stk_q;
  logic [SH_W-1:0]                 sh_cnt_q;
  logic [7*(DIGITS+2)-1:0]         disp_q;
  logic                            ovf_q, upd_q;

  logic                            tc, adv, sel_hit, start, conv_ovf, nz;
  logic [DIGITS-1:0]               dig_blank;
  logic [DIGITS-1:0][6:0]          dig_seg;

  assign tc      = !hold_i && (dwell_q == CNT_W'(DWELL_CYC - 1));
  assign adv     = tc || next_i;              // tc and next together: one step
  assign sel_hit = ch_valid_i[ch_sel_q];
  assign start   = (state_q == IDLE) && pending_q;

  // Capture incoming readings per channel.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      samples_q <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++)
        if (ch_valid_i[k]) samples_q[k] <= ch_data_i[k*DATA_W +: DATA_W];
    end
  end

  // Dwell counter and channel rotation; next_i overrides hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dwell_q  <= '0;
      ch_sel_q <= '0;
    end else if (adv) begin
      dwell_q  <= '0;
      ch_sel_q <= (ch_sel_q == SEL_W'(NUM_CH - 1)) ? '0 : ch_sel_q + 1'b1;
    end else if (!hold_i) begin
      dwell_q  <= dwell_q + 1'b1;
    end
  end

  // Pending request: set wins over the clear at conversion start, so a
  // request arriving on the start edge re-runs the conversion.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pending_q <= 1'b1;
    else         pending_q <= adv || sel_hit || (pending_q && !start);
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pending_q) state_d = SHIFT;
      SHIFT:   if (sh_cnt_q == SH_W'(DATA_W - 1)) state_d = LOAD;
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Double-dabble correction: add 3 to every nibble >= 5 before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NIB; i++)
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
  end

  // Conversion datapath: snapshot on start, one bit per SHIFT cycle. A bit
  // carried out of the top nibble is kept sticky so wide inputs still flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bin_q     <= '0;
      bcd_q     <= '0;
      ovf_stk_q <= 1'b0;
      tag_q     <= '0;
      sh_cnt_q  <= '0;
    end else if (start) begin
      bin_q     <= samples_q[ch_sel_q];
      tag_q     <= ch_sel_q;
      bcd_q     <= '0;
      ovf_stk_q <= 1'b0;
      sh_cnt_q  <= '0;
    end else if (state_q == SHIFT) begin
      bin_q     <= bin_q << 1;
      bcd_q     <= {bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};
      ovf_stk_q <= ovf_stk_q | bcd_adj[BCD_W-1];
      sh_cnt_q  <= sh_cnt_q + 1'b1;
    end
  end

  assign conv_ovf = ovf_stk_q || (bcd_q[BCD_W-1 -: 4] != 4'd0);

  // Leading-zero blanking from the MSD down; the LSD is never blanked.
  always_comb begin
    dig_blank = '0;
    nz        = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      nz           = nz | (|bcd_q[i*4 +: 4]);
      dig_blank[i] = !nz;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    sensor_disp_seg u_seg (
      .bcd   (bcd_q[g*4 +: 4]),
      .blank (dig_blank[g]),
      .dash  (conv_ovf),
      .seg   (dig_seg[g])
    );
  end

  // Output register: only a result for the still-selected channel lands.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      disp_q <= '1;
      ovf_q  <= 1'b0;
      upd_q  <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      if (state_q == LOAD && tag_q == ch_sel_q) begin
        disp_q <= {dig_seg, ch_suffix_i[tag_q*14 +: 14]};
        ovf_q  <= conv_ovf;
        upd_q  <= 1'b1;
      end
    end
  end

  assign disp_o   = disp_q;
  assign ovf_o    = ovf_q;
  assign upd_o    = upd_q;
  assign ch_sel_o = ch_sel_q;
endmodule
